// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the SDF FFT stage controllers.
//   state_t      : controller state (IDLE, FILL, RUN, FLUSH)
//   WL           : datapath word length of the S7.11 samples handled beside the controller
//   stage_delay  : delay-line depth D = N >> (STAGE+1) for a given LOG2_N / STAGE
//   stage_ld     : LD = log2(D)
package fft_ctrl_pkg;

    localparam int WL = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic int stage_ld(input int log2_n, input int stage);
        return log2_n - stage - 1;
    endfunction

    function automatic int stage_delay(input int log2_n, input int stage);
        return 1 << stage_ld(log2_n, stage);
    endfunction

endpackage

// File: rtl/sdf_tw_addr_gen.sv
// Twiddle address generator for one SDF stage.
// Keeps the in-block position j (0..D-1) and maps it to the twiddle ROM
// address j << STAGE.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force j back to 0 (takes priority over step)
//   step     : advance j by one, wrapping D-1 -> 0
//   addr     : twiddle ROM address for the current j (combinational)
//   last     : j is at D-1
module sdf_tw_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2_N = 4,
    parameter int STAGE  = 0,
    parameter int TW_AW  = LOG2_N - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    output logic [TW_AW-1:0] addr,
    output logic             last
);

    localparam int D  = stage_delay(LOG2_N, STAGE);
    localparam int LD = stage_ld(LOG2_N, STAGE);
    // D = 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int JW = (LD > 0) ? LD : 1;
    localparam logic [JW-1:0] J_LAST = JW'(D - 1);

    logic [JW-1:0] j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j <= '0;
        end else if (clear) begin
            j <= '0;
        end else if (step) begin
            j <= (j == J_LAST) ? '0 : j + 1'b1;
        end
    end

    always_comb begin
        addr = TW_AW'(j) << STAGE;
        last = (j == J_LAST);
    end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage.
// Drives the feedback/butterfly select, delay-line shift enable, twiddle
// ROM address/enable and output framing. All outputs except in_ready are
// registered and describe the sample accepted one cycle earlier.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input sample present          in_ready : samples accepted (not in FLUSH)
//   flush_req  : drain delay line at a block boundary
//   sel        : 0 = delay-line feedback, 1 = butterfly result
//   shift_en   : advance delay line             tw_en/tw_addr : twiddle multiply / ROM address
//   out_valid  : stage output valid             out_first : first output of an N-sample frame
//   flush_err  : flush_req at an illegal point   busy : controller not idle
module sdf_stage_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2_N = 4,
    parameter int STAGE  = 0,
    parameter int TW_AW  = LOG2_N - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush_req,
    output logic             sel,
    output logic             shift_en,
    output logic             tw_en,
    output logic [TW_AW-1:0] tw_addr,
    output logic             out_valid,
    output logic             out_first,
    output logic             flush_err,
    output logic             busy
);

    localparam int D  = stage_delay(LOG2_N, STAGE);
    localparam int LD = stage_ld(LOG2_N, STAGE);
    localparam logic [LOG2_N-1:0] FILL_LAST = LOG2_N'(D - 1);
    localparam logic [LOG2_N-1:0] BLK_MASK  = LOG2_N'(2 * D - 1);

    state_t            state, state_n;
    logic [LOG2_N-1:0] cnt, cnt_n, cnt_post;
    logic [LOG2_N-1:0] ocnt, ocnt_n;
    logic              accept, boundary;
    logic              j_clear, j_step, j_last;
    logic [TW_AW-1:0]  addr;
    logic              sel_n, shift_en_n, tw_en_n, out_valid_n, out_first_n, flush_err_n;
    logic [TW_AW-1:0]  tw_addr_n;

    sdf_tw_addr_gen #(
        .LOG2_N (LOG2_N),
        .STAGE  (STAGE),
        .TW_AW  (TW_AW)
    ) u_tw_addr (
        .clk   (clk),
        .rst   (rst),
        .clear (j_clear),
        .step  (j_step),
        .addr  (addr),
        .last  (j_last)
    );

    assign in_ready = (state != FLUSH);
    assign accept   = in_valid & in_ready;
    // Flush legality is judged after counting a same-cycle sample.
    assign cnt_post = accept ? cnt + 1'b1 : cnt;
    assign boundary = ((cnt_post & BLK_MASK) == '0);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ocnt_n      = ocnt;
        sel_n       = sel;
        tw_addr_n   = tw_addr;
        shift_en_n  = 1'b0;
        tw_en_n     = 1'b0;
        out_valid_n = 1'b0;
        out_first_n = 1'b0;
        flush_err_n = 1'b0;
        j_clear     = 1'b0;
        j_step      = 1'b0;

        // A flush during FILL drops the sample of that cycle together with the partial fill.
        if (accept && !(state == FILL && flush_req)) begin
            shift_en_n = 1'b1;
            sel_n      = cnt[LD];
            tw_addr_n  = addr;
            j_step     = 1'b1;
            cnt_n      = cnt_post;
            if (state == RUN) begin
                out_valid_n = 1'b1;
                tw_en_n     = ~cnt[LD];
                out_first_n = (ocnt == '0);
                ocnt_n      = ocnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (D == 1) ? RUN : FILL;
                end
            end
            FILL: begin
                if (flush_req) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ocnt_n  = '0;
                    j_clear = 1'b1;
                end else if (accept && cnt == FILL_LAST) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    if (boundary) begin
                        state_n = FLUSH;
                    end else begin
                        flush_err_n = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Entered on a block boundary, so j starts the drain at 0.
                shift_en_n  = 1'b1;
                sel_n       = 1'b0;
                out_valid_n = 1'b1;
                tw_en_n     = 1'b1;
                tw_addr_n   = addr;
                j_step      = 1'b1;
                if (j_last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ocnt_n  = '0;
                    j_clear = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ocnt      <= '0;
            sel       <= 1'b0;
            shift_en  <= 1'b0;
            tw_en     <= 1'b0;
            tw_addr   <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            flush_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ocnt      <= ocnt_n;
            sel       <= sel_n;
            shift_en  <= shift_en_n;
            tw_en     <= tw_en_n;
            tw_addr   <= tw_addr_n;
            out_valid <= out_valid_n;
            out_first <= out_first_n;
            flush_err <= flush_err_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule
